// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the floating-point multiply path.
package fp_mul_pkg;

   // Significand width of IEEE-754 single precision, hidden bit included.
   localparam int MANT_W = 24;

   // Width of the exact significand product.
   localparam int PROD_W = 2 * MANT_W;

   // Control states of the sequential significand multiplier.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

endpackage : fp_mul_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the ripple-carry adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with carry-in tied to zero and carry-out exposed.
module ripple_carry_adder #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   // carry[i] feeds bit i; carry[WIDTH] is the final carry-out.
   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a     (a[i]),
         .b     (b[i]),
         .c_in  (carry[i]),
         .sum   (sum[i]),
         .c_out (carry[i+1])
      );
   end

   assign c_out = carry[WIDTH];

endmodule : ripple_carry_adder

// File: rtl/mant_seq_multiplier.sv
// Sequential shift-and-add multiplier for floating-point significands.
// One multiplier bit is retired per clock; the exact 2*WIDTH-bit product is
// presented in DONE and held until the downstream handshake completes.
module mant_seq_multiplier
   import fp_mul_pkg::*;
#(
   parameter int WIDTH = MANT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   mul_state_e       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Partial-product add: acc_hi plus the multiplicand gated by the current
   // multiplier bit. The carry-out becomes the new top bit after the shift.
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             sum_c;

   assign addend = mplr_q[0] ? mcand_q : '0;

   ripple_carry_adder #(
      .WIDTH (WIDTH)
   ) u_rca (
      .a     (acc_hi_q),
      .b     (addend),
      .sum   (sum),
      .c_out (sum_c)
   );

   // Next-state, datapath update and handshake decode.
   // NOTE: every signal written here gets a default first so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d  = RUN;
               mcand_d  = a;
               mplr_d   = b;
               acc_hi_d = '0;
               acc_lo_d = '0;
               cnt_d    = '0;
            end
         end

         RUN: begin
            // {carry, sum, acc_lo} shifted right by one: the bit leaving
            // sum[0] is a finished low-order product bit.
            acc_hi_d = {sum_c, sum[WIDTH-1:1]};
            acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
            mplr_d   = mplr_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end

         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   // NOTE: the datapath registers are reset too, not just the FSM, because
   // product is driven straight from the accumulator and must read 0 after reset.
   // NOTE: non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         cnt_q    <= cnt_d;
      end
   end

   assign product = {acc_hi_q, acc_lo_q};

endmodule : mant_seq_multiplier

// File: tb/tb_mant_seq_multiplier.sv
// Self-checking bench for mant_seq_multiplier: directed vector table,
// hand-written corner sequences, then randomised transactions against a*b.
module tb_mant_seq_multiplier;
   import fp_mul_pkg::*;

   localparam int W        = MANT_W;
   localparam int MAX_WAIT = 4 * W;
   localparam int N_VEC    = 10;
   localparam int N_RAND   = 1000;

   typedef struct {
      logic [W-1:0]      a;
      logic [W-1:0]      b;
      logic [PROD_W-1:0] exp;
      string             name;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      a;
   logic [W-1:0]      b;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] product;

   int total = 0;
   int bad   = 0;

   vec_t vecs [N_VEC];

   always #5 clk = ~clk;

   mant_seq_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Waits (bounded) for in_ready, then presents one operand pair for one edge.
   // Returns at the negedge after the accept edge with scrambled operands.
   task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
      int n;
      n = 0;
      while (!in_ready && n < MAX_WAIT) begin
         @(negedge clk);
         n++;
      end
      check({name, " in_ready before accept"}, 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      @(negedge clk);
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
   endtask

   // Counts cycles from the accept edge until out_valid; start_cyc accounts for
   // cycles already spent by the caller. With noise, in_valid/out_ready toggle
   // randomly while busy and must be ignored.
   task automatic wait_result(input logic [PROD_W-1:0] exp, input string name,
                              input int start_cyc, input bit noise);
      int cyc;
      cyc = start_cyc;
      while (!out_valid && cyc < MAX_WAIT) begin
         if (noise) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({name, " latency"}, 64'(cyc), 64'(W));
      check({name, " product"}, 64'(product), 64'(exp));
   endtask

   // Holds out_ready low for hold cycles checking the result is stable, then
   // completes the handshake and checks the return to IDLE one cycle later.
   task automatic release_result(input logic [PROD_W-1:0] exp, input string name, input int hold);
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         @(negedge clk);
         check({name, " held out_valid"}, 64'(out_valid), 64'(1));
         check({name, " held product"}, 64'(product), 64'(exp));
         check({name, " held in_ready"}, 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, " out_valid after handshake"}, 64'(out_valid), 64'(0));
      check({name, " in_ready after handshake"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      logic [W-1:0]      ra;
      logic [W-1:0]      rb;
      logic [PROD_W-1:0] rexp;
      int                seen;

      vecs[0] = '{24'h000003, 24'h000005, 48'h00000000000F, "3x5"};
      vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max x max"};
      vecs[2] = '{24'h800000, 24'h800000, 48'h400000000000, "1.0 x 1.0"};
      vecs[3] = '{24'h000000, 24'hABCDEF, 48'h000000000000, "0 x abcdef"};
      vecs[4] = '{24'hABCDEF, 24'h000000, 48'h000000000000, "abcdef x 0"};
      vecs[5] = '{24'h000001, 24'hFFFFFF, 48'h000000FFFFFF, "1 x max"};
      vecs[6] = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, "max x 1"};
      vecs[7] = '{24'h123456, 24'h000010, 48'h000001234560, "123456 x 10"};
      vecs[8] = '{24'hFFFFFF, 24'h800000, 48'h7FFFFF800000, "max x 1.0"};
      vecs[9] = '{24'h000002, 24'h000003, 48'h000000000006, "2x3"};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset in_ready", 64'(in_ready), 64'(1));
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset product", 64'(product), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Directed vector table, out_ready asserted as soon as the result shows.
      for (int i = 0; i < N_VEC; i++) begin
         accept(vecs[i].a, vecs[i].b, vecs[i].name);
         wait_result(vecs[i].exp, vecs[i].name, 0, 1'b0);
         release_result(vecs[i].exp, vecs[i].name, 0);
      end

      // Back-pressure: result held for 10 cycles, then one-edge handshake.
      accept(24'h000003, 24'h000005, "backpressure");
      wait_result(48'h00000000000F, "backpressure", 0, 1'b0);
      release_result(48'h00000000000F, "backpressure", 10);

      // Busy ignore: in_valid pulsed with 7x9 at cycle 5 of a 3x5 run.
      accept(24'h000003, 24'h000005, "busy");
      repeat (4) @(negedge clk);
      in_valid = 1'b1;
      a        = 24'h000007;
      b        = 24'h000009;
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(48'h00000000000F, "busy", 5, 1'b0);
      release_result(48'h00000000000F, "busy", 0);
      seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      out_ready = 1'b0;
      check("busy no second result", 64'(seen), 64'(0));

      // Reset mid-run at cycle 12 of max x max, then a clean 2x2.
      accept(24'hFFFFFF, 24'hFFFFFF, "midreset");
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset in_ready", 64'(in_ready), 64'(1));
      check("midreset out_valid", 64'(out_valid), 64'(0));
      check("midreset product", 64'(product), 64'(0));
      accept(24'h000002, 24'h000002, "after reset");
      wait_result(48'h000000000004, "after reset", 0, 1'b0);
      release_result(48'h000000000004, "after reset", 0);

      // Random pairs with idle gaps, busy-time noise and random back-pressure.
      for (int i = 0; i < N_RAND; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         ra   = W'($urandom);
         rb   = W'($urandom);
         rexp = PROD_W'(ra) * PROD_W'(rb);
         accept(ra, rb, "random");
         wait_result(rexp, "random", 0, 1'b1);
         release_result(rexp, "random", int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mant_seq_multiplier
